// File: rtl/r200_pkg.sv
// r200 shared definitions: datapath widths, writeback select
// encodings and per-boundary stage payload widths.
package r200_pkg;

  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PCP4 = 2'd2
  } wbsel_e;

  localparam int WBSEL_W = $bits(wbsel_e);

  // pc + instr
  localparam int IFID_W  = 2 * XLEN;
  // pc, rs1/rs2 values, imm, rd, wbsel
  localparam int IDEX_W  = 4 * XLEN + REGADDR_W + WBSEL_W;
  // alu result, store data, pc+4, rd, wbsel
  localparam int EXMEM_W = 3 * XLEN + REGADDR_W + WBSEL_W;
  // writeback value, rd
  localparam int MEMWB_W = XLEN + REGADDR_W;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with enable and async active-high reset.
// Only built when PIPE_STAGE_PERF_EN is defined.
`ifdef PIPE_STAGE_PERF_EN
module pipe_sat_cnt #(
  parameter int CNTW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  output logic [CNTW-1:0] o_cnt
);

  logic [CNTW-1:0] r_cnt;

  // count enabled events, stick at all-ones
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_en && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/pipe_stage.sv
// Pipeline stage register: valid/ready, 2-entry skid, flush, occupancy.
// PIPE_STAGE_PERF_EN adds stall/flush saturating perf counters.
module pipe_stage
  import r200_pkg::*;
#(
  parameter int               WIDTH   = XLEN,
  parameter logic [WIDTH-1:0] RST_VAL = '0
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int               CNTW    = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occ
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNTW-1:0]  stall_cnt,
  output logic [CNTW-1:0]  flush_cnt
`endif
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_in_ready;
  logic [1:0]       r_occ;

  logic w_acc;
  logic w_main_free;
  logic w_ov_n;
  logic w_sv_n;
  logic w_ld_main_skid;
  logic w_ld_main_in;
  logic w_ld_skid;

  assign w_acc       = in_valid && r_in_ready;
  assign w_main_free = !r_out_valid || out_ready;

  // next occupancy and which register loads what
  always_comb begin
    w_ov_n         = r_out_valid;
    w_sv_n         = r_skid_valid;
    w_ld_main_skid = 1'b0;
    w_ld_main_in   = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_ov_n = 1'b0;
      w_sv_n = 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        w_ld_main_skid = 1'b1;
        w_ov_n         = 1'b1;
        w_sv_n         = 1'b0;
      end else if (w_acc) begin
        w_ld_main_in = 1'b1;
        w_ov_n       = 1'b1;
      end else begin
        w_ov_n = 1'b0;
      end
    end else if (w_acc) begin
      w_ld_skid = 1'b1;
      w_sv_n    = 1'b1;
    end
  end

  // valid flags; in_ready/occ registered from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_occ        <= 2'd0;
    end else begin
      r_out_valid  <= w_ov_n;
      r_skid_valid <= w_sv_n;
      r_in_ready   <= !w_sv_n;
      r_occ        <= {1'b0, w_ov_n} + {1'b0, w_sv_n};
    end
  end

  // payload registers; flush leaves contents alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= RST_VAL;
      r_skid_data <= '0;
    end else begin
      if (w_ld_main_skid)
        r_out_data <= r_skid_data;
      else if (w_ld_main_in)
        r_out_data <= in_data;
      if (w_ld_skid)
        r_skid_data <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign occ       = r_occ;

`ifdef PIPE_STAGE_PERF_EN
  logic w_stall_ev;
  logic w_flush_ev;

  assign w_stall_ev = r_out_valid && !out_ready;
  assign w_flush_ev = flush && (r_occ != 2'd0);

  pipe_sat_cnt #(.CNTW(CNTW)) u_stall_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_stall_ev),
    .o_cnt (stall_cnt)
  );

  pipe_sat_cnt #(.CNTW(CNTW)) u_flush_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_flush_ev),
    .o_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: FIFO reference model,
// directed scenarios then randomized traffic.
module tb_pipe_stage;

  localparam int         W    = 8;
  localparam logic [7:0] RV   = 8'h13;
  localparam int         CMAX = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]   stall_cnt;
  logic [3:0]   flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage #(
    .WIDTH   (W),
    .RST_VAL (RV)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .CNTW    (4)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occ       (occ)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model: entries held in the stage, oldest first
  logic [W-1:0] mq[$];
  // scoreboard: payloads predicted to drain
  logic [W-1:0] exp_q[$];
  int m_stall = 0;
  int m_flush = 0;

  bit         chk_en = 1'b0;
  logic       e_ov;
  logic       e_rdy;
  int         e_occ;
  logic [W-1:0] e_head;
  int         e_stall;
  int         e_flush;

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // one cycle: publish expected state, drive inputs, advance model
  task automatic cycle(bit v, logic [W-1:0] d, bit ordy, bit fl);
    int c;
    @(negedge clk);
    c       = mq.size();
    e_occ   = c;
    e_ov    = (c > 0);
    e_rdy   = (c < 2);
    e_head  = (c > 0) ? mq[0] : '0;
    e_stall = m_stall;
    e_flush = m_flush;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    if (c > 0 && ordy)
      exp_q.push_back(mq.pop_front());
    if (c > 0 && !ordy && m_stall < CMAX)
      m_stall++;
    if (fl && c > 0 && m_flush < CMAX)
      m_flush++;
    if (fl)
      mq.delete();
    else if (v && c < 2)
      mq.push_back(d);
    chk_en = 1'b1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    chk_en    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_occ", occ, 0);
    check("arst_out_data", out_data, RV);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_stall = 0;
    m_flush = 0;
  endtask

  // monitor: compare state and pop scoreboard on each drain
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (chk_en && !rst) begin
        check("occ", occ, e_occ);
        check("out_valid", out_valid, e_ov);
        check("in_ready", in_ready, e_rdy);
        if (e_ov)
          check("out_data", out_data, e_head);
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cnt", stall_cnt, e_stall);
        check("flush_cnt", flush_cnt, e_flush);
`endif
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL drain: got %0h expected none",
                     out_data);
          end else begin
            check("drain_data", out_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occ", occ, 0);
    check("rst_out_data", out_data, RV);
`ifdef PIPE_STAGE_PERF_EN
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    #4 check("stall_sat", stall_cnt, 15);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    #4 check("flush_once", flush_cnt, 1);
    async_reset();
`endif

    // streaming at full rate
    cycle(1'b1, 8'h10, 1'b1, 1'b0);
    cycle(1'b1, 8'h11, 1'b1, 1'b0);
    cycle(1'b1, 8'h12, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // skid fill, upstream held, then release
    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 8'hA3, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 8'hA3, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // flush at occ=2 with a simultaneous offer
    cycle(1'b1, 8'hB1, 1'b0, 1'b0);
    cycle(1'b1, 8'hB2, 1'b0, 1'b0);
    cycle(1'b1, 8'hB0, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // flush and drain in the same cycle
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // async reset while holding two entries
    cycle(1'b1, 8'hD1, 1'b0, 1'b0);
    cycle(1'b1, 8'hD2, 1'b0, 1'b0);
    async_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7,
            W'($urandom),
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 5);
    end
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    #5;
    check("missed_drains", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
